// File: rtl/io_port_unit.sv
// Processor I/O port: an input FIFO fed by an external producer and drained by InRead,
// and an output FIFO filled by OutputWrite and drained by an external consumer.
module io_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] headData,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wrPtr_r;
    logic [PW-1:0]    rdPtr_r;
    logic [CW-1:0]    count_r;

    // Storage, wrapping pointers and occupancy; push/pop arrive already qualified.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wrPtr_r] <= pushData;
                wrPtr_r        <= wrPtr_r + PW'(1);
            end
            if (pop) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head is zero whenever the FIFO is empty, including straight out of reset.
    always_comb begin
        headData = {WIDTH{1'b0}};
        if (count_r != {CW{1'b0}}) begin
            headData = mem_r[rdPtr_r];
        end else begin
            headData = {WIDTH{1'b0}};
        end
    end

    assign count = count_r;
endmodule

module io_port_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     OutputWrite,
    input  logic                     InRead,
    input  logic [WIDTH-1:0]         WriteData,
    output logic [WIDTH-1:0]         InData,
    input  logic                     ClearFlags,
    input  logic [WIDTH-1:0]         ext_in_data,
    input  logic                     ext_in_valid,
    output logic                     ext_in_ready,
    output logic [WIDTH-1:0]         ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    output logic [$clog2(DEPTH):0]   InCount,
    output logic [$clog2(DEPTH):0]   OutCount,
    output logic                     Underflow,
    output logic                     Overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY = {CW{1'b0}};

    logic inPush_s, inPop_s, outPush_s, outPop_s, underSet_s, overSet_s;
    logic underflow_r, overflow_r;

    // Qualify strobes; a full output FIFO still takes a write when the consumer frees a slot.
    always_comb begin
        inPush_s   = 1'b0;
        inPop_s    = 1'b0;
        outPush_s  = 1'b0;
        outPop_s   = 1'b0;
        underSet_s = 1'b0;
        overSet_s  = 1'b0;
        if (InCount != EMPTY) begin
            inPop_s = InRead;
        end else begin
            underSet_s = InRead;
        end
        inPush_s = ext_in_valid & ext_in_ready;
        outPop_s = ext_out_valid & ext_out_ready;
        if ((OutCount != FULL) || outPop_s) begin
            outPush_s = OutputWrite;
        end else begin
            overSet_s = OutputWrite;
        end
    end

    io_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) inFifo (
        .CLK(CLK), .Reset(Reset), .push(inPush_s), .pop(inPop_s),
        .pushData(ext_in_data), .headData(InData), .count(InCount)
    );

    io_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) outFifo (
        .CLK(CLK), .Reset(Reset), .push(outPush_s), .pop(outPop_s),
        .pushData(WriteData), .headData(ext_out_data), .count(OutCount)
    );

    // Sticky error flags; a set event in the same cycle as ClearFlags wins.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (underSet_s) begin
                underflow_r <= 1'b1;
            end else if (ClearFlags) begin
                underflow_r <= 1'b0;
            end
            if (overSet_s) begin
                overflow_r <= 1'b1;
            end else if (ClearFlags) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign ext_in_ready  = (InCount < FULL);
    assign ext_out_valid = (OutCount != EMPTY);
    assign Underflow     = underflow_r;
    assign Overflow      = overflow_r;
endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: constant vector table, directed corner sequences
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_io_port_unit;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        OutputWrite, InRead, ClearFlags;
    logic [15:0] WriteData, InData, ext_in_data, ext_out_data;
    logic        ext_in_valid, ext_in_ready, ext_out_valid, ext_out_ready;
    logic [2:0]  InCount, OutCount;
    logic        Underflow, Overflow;

    always #5 CLK = ~CLK;

    io_port_unit dut (
        .CLK(CLK), .Reset(Reset), .OutputWrite(OutputWrite), .InRead(InRead),
        .WriteData(WriteData), .InData(InData), .ClearFlags(ClearFlags),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .InCount(InCount), .OutCount(OutCount), .Underflow(Underflow), .Overflow(Overflow)
    );

    int nChecks = 0;
    int nFail = 0;
    logic [15:0] inQ[$];
    logic [15:0] outQ[$];
    bit mUnder, mOver;
    logic [15:0] outDel[$];
    logic [15:0] inDel[$];

    typedef struct {
        bit          iv;
        logic [15:0] id;
        bit          rd;
        logic [15:0] eData;
        int          eCnt;
        bit          eRdy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        chk("InData", 32'(InData), (inQ.size() > 0) ? 32'(inQ[0]) : 32'h0);
        chk("InCount", 32'(InCount), inQ.size());
        chk("ext_in_ready", 32'(ext_in_ready), 32'(inQ.size() < 4));
        chk("ext_out_data", 32'(ext_out_data), (outQ.size() > 0) ? 32'(outQ[0]) : 32'h0);
        chk("ext_out_valid", 32'(ext_out_valid), 32'(outQ.size() > 0));
        chk("OutCount", 32'(OutCount), outQ.size());
        chk("Underflow", 32'(Underflow), 32'(mUnder));
        chk("Overflow", 32'(Overflow), 32'(mOver));
    endtask

    task automatic driveCheck(input bit iv, input logic [15:0] id, input bit rd, input bit ow,
                              input logic [15:0] wd, input bit ordy, input bit clr);
        @(negedge CLK);
        ext_in_valid = iv; ext_in_data = id; InRead = rd; OutputWrite = ow;
        WriteData = wd; ext_out_ready = ordy; ClearFlags = clr;
        #1;
        checkModel();
        if (ext_out_valid && ext_out_ready) outDel.push_back(ext_out_data);
        if (InRead && InCount != 3'd0) inDel.push_back(InData);
    endtask

    // Reference behaviour: pops take the old head, then accepted pushes append.
    task automatic clockEdge();
        int  inN = inQ.size();
        int  outN = outQ.size();
        bit  outPop = (outN > 0) && ext_out_ready;
        bit  outPushOk = OutputWrite && ((outN < 4) || outPop);
        bit  underSet = InRead && (inN == 0);
        bit  overSet = OutputWrite && !outPushOk;
        if (InRead && inN > 0) void'(inQ.pop_front());
        if (ext_in_valid && inN < 4) inQ.push_back(ext_in_data);
        if (outPop) void'(outQ.pop_front());
        if (outPushOk) outQ.push_back(WriteData);
        mUnder = underSet ? 1'b1 : (ClearFlags ? 1'b0 : mUnder);
        mOver  = overSet  ? 1'b1 : (ClearFlags ? 1'b0 : mOver);
        @(posedge CLK);
    endtask

    task automatic cyc(input bit iv, input logic [15:0] id, input bit rd, input bit ow,
                       input logic [15:0] wd, input bit ordy, input bit clr);
        driveCheck(iv, id, rd, ow, wd, ordy, clr);
        clockEdge();
    endtask

    initial begin
        int maxC;
        Reset = 1'b1; OutputWrite = 1'b0; InRead = 1'b0; ClearFlags = 1'b0;
        WriteData = 16'h0; ext_in_data = 16'h0; ext_in_valid = 1'b0; ext_out_ready = 1'b0;

        tbl[0] = '{1'b1, 16'h1111, 1'b0, 16'h0000, 0, 1'b1};
        tbl[1] = '{1'b1, 16'h2222, 1'b0, 16'h1111, 1, 1'b1};
        tbl[2] = '{1'b1, 16'h3333, 1'b0, 16'h1111, 2, 1'b1};
        tbl[3] = '{1'b1, 16'h4444, 1'b0, 16'h1111, 3, 1'b1};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h1111, 4, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 16'h1111, 4, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 16'h2222, 3, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 16'h3333, 2, 1'b1};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 16'h4444, 1, 1'b1};
        tbl[9] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b1};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_InCount", 32'(InCount), 32'd0);
        chk("rst_OutCount", 32'(OutCount), 32'd0);
        chk("rst_ready", 32'(ext_in_ready), 32'd1);
        chk("rst_valid", 32'(ext_out_valid), 32'd0);
        chk("rst_InData", 32'(InData), 32'd0);
        chk("rst_out_data", 32'(ext_out_data), 32'd0);
        chk("rst_Underflow", 32'(Underflow), 32'd0);
        chk("rst_Overflow", 32'(Overflow), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // Input fill/drain, starting on the first edge after reset release.
        for (int i = 0; i < 10; i++) begin
            driveCheck(tbl[i].iv, tbl[i].id, tbl[i].rd, 1'b0, 16'h0, 1'b0, 1'b0);
            chk("tbl_InData", 32'(InData), 32'(tbl[i].eData));
            chk("tbl_InCount", 32'(InCount), tbl[i].eCnt);
            chk("tbl_ready", 32'(ext_in_ready), 32'(tbl[i].eRdy));
            clockEdge();
        end

        // Underflow, clear, and set-beats-clear.
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        #1 chk("under_set", 32'(Underflow), 32'd1);
        chk("under_cnt", 32'(InCount), 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        #1 chk("under_clr", 32'(Underflow), 32'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        #1 chk("under_set_wins", 32'(Underflow), 32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Output backpressure with one dropped write.
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        #1 chk("bp_OutCount", 32'(OutCount), 32'd4);
        chk("bp_Overflow", 32'(Overflow), 32'd1);
        chk("bp_head", 32'(ext_out_data), 32'hA000);
        outDel.delete();
        repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("bp_delivered", outDel.size(), 32'd4);
        for (int i = 0; i < outDel.size(); i++) chk("bp_word", 32'(outDel[i]), 32'hA000 + i);

        // Full output FIFO accepting a write thanks to a same-cycle pop.
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
        outDel.delete();
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        #1 chk("fullpop_OutCount", 32'(OutCount), 32'd4);
        chk("fullpop_Overflow", 32'(Overflow), 32'd0);
        repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("fullpop_count", outDel.size(), 32'd5);
        if (outDel.size() == 5) chk("fullpop_fifth", 32'(outDel[4]), 32'hBEEF);

        // Pointer wrap with interleaved push/pop.
        inDel.delete();
        maxC = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'(i), i > 0, 1'b0, 16'h0, 1'b0, 1'b0);
            #1 if (int'(InCount) > maxC) maxC = int'(InCount);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("wrap_reads", inDel.size(), 32'd10);
        for (int i = 0; i < inDel.size(); i++) chk("wrap_word", 32'(inDel[i]), i);
        chk("wrap_max_le1", 32'(maxC <= 1), 32'd1);

        // Asynchronous reset between edges with both FIFOs holding three words.
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        chk("arst_InCount", 32'(InCount), 32'd0);
        chk("arst_OutCount", 32'(OutCount), 32'd0);
        chk("arst_valid", 32'(ext_out_valid), 32'd0);
        chk("arst_ready", 32'(ext_in_ready), 32'd1);
        chk("arst_InData", 32'(InData), 32'd0);
        inQ.delete(); outQ.delete(); mUnder = 1'b0; mOver = 1'b0;
        ext_in_valid = 1'b1; OutputWrite = 1'b1;
        @(posedge CLK);
        #1 chk("arst_nopush_in", 32'(InCount), 32'd0);
        chk("arst_nopush_out", 32'(OutCount), 32'd0);
        @(negedge CLK);
        Reset = 1'b0; ext_in_valid = 1'b0; OutputWrite = 1'b0;
        cyc(1'b1, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1 chk("arst_first_push", 32'(InData), 32'h5555);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) == 0);
        end
        driveCheck(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/io_port_unit.md
IO_PORT_UNIT -- requirements
Module: io_port_unit

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, 16, data word width.
  - DEPTH, 4, entries per FIFO (power of two).
REQ-002 Ports SHALL be:
  - CLK  input  1  rising-edge clock.
  - Reset  input  1  reset.
  - OutputWrite  input  1  push strobe for the output FIFO, from the control unit "out" state.
  - InRead  input  1  pop strobe for the input FIFO, from the control unit "in" state.
  - WriteData  input  WIDTH  register-B value to send.
  - InData  output  WIDTH  input FIFO head, consumed by the MemtoReg=2 register write path.
  - ClearFlags  input  1  synchronous clear of the sticky flags.
  - ext_in_data  input  WIDTH  external producer word.
  - ext_in_valid  input  1  external producer word valid.
  - ext_in_ready  output  1  input FIFO can accept.
  - ext_out_data  output  WIDTH  output FIFO head.
  - ext_out_valid  output  1  output FIFO non-empty.
  - ext_out_ready  input  1  external consumer accepts.
  - InCount  output  log2(DEPTH)+1  input FIFO occupancy.
  - OutCount  output  log2(DEPTH)+1  output FIFO occupancy.
  - Underflow  output  1  sticky: InRead while input FIFO empty.
  - Overflow  output  1  sticky: OutputWrite dropped.
REQ-003 The block SHALL use one clock, CLK; Reset SHALL be asynchronous and active-high.

Function
REQ-004 Both FIFOs SHALL be first-in first-out, with registered storage, read/write pointers and an occupancy count, all updated only on the rising edge of CLK.
REQ-005 An input push SHALL occur on an edge where ext_in_valid and ext_in_ready are both 1.
REQ-006 ext_in_ready SHALL equal (InCount < DEPTH), decoded combinationally from the registered count, independent of ext_in_valid.
REQ-007 InData SHALL present the input FIFO head combinationally when InCount > 0, and SHALL be 0 when InCount = 0.
REQ-008 InRead with InCount > 0 SHALL pop one entry on the edge; the word popped SHALL be the InData value of that same cycle.
REQ-009 InRead with InCount = 0 SHALL NOT move pointers or count, and SHALL set Underflow; a push in the same cycle SHALL still be accepted.
REQ-010 A simultaneous input push and pop with 0 < InCount < DEPTH SHALL leave InCount unchanged.
REQ-011 OutputWrite SHALL push WriteData on the edge if OutCount < DEPTH, or if OutCount = DEPTH and an external pop (ext_out_valid and ext_out_ready) occurs in the same cycle.
REQ-012 OutputWrite with OutCount = DEPTH and no same-cycle pop SHALL drop the word and set Overflow; FIFO contents SHALL be unchanged.
REQ-013 ext_out_valid SHALL equal (OutCount > 0); ext_out_data SHALL be the output FIFO head, and 0 when empty.
REQ-014 Output data SHALL be held stable while ext_out_valid = 1 and ext_out_ready = 0.
REQ-015 Latency: a word pushed at edge N SHALL be visible on InData or ext_out_data from just after edge N when that FIFO was empty; the source-to-output latency is 1 cycle.
REQ-016 Pointers SHALL wrap modulo DEPTH; counts SHALL saturate at neither 0 nor DEPTH, which is guaranteed by REQ-006, REQ-009 and REQ-012.
REQ-017 Underflow and Overflow SHALL remain set until ClearFlags.
REQ-018 If ClearFlags and a new set event occur in the same cycle, the set SHALL win.

Reset
REQ-019 On Reset assertion, immediately and independent of CLK, the block SHALL force:
  - all pointers and counts to 0;
  - Underflow = Overflow = 0;
  - InData = ext_out_data = 0;
  - ext_out_valid = 0 and ext_in_ready = 1.
REQ-020 Reset asserted mid-transfer SHALL discard all buffered words; no push or pop SHALL occur on an edge while Reset = 1.
REQ-021 The first push SHALL be accepted on the first rising edge after Reset deasserts.

Verification
REQ-022 Input fill/drain: push 0x1111, 0x2222, 0x3333, 0x4444 -> ext_in_ready = 0 and InCount = 4; four InReads -> InData sequence 0x1111..0x4444, then InData = 0 and ext_in_ready = 1.
REQ-023 Underflow: InRead on an empty FIFO -> Underflow = 1 and InCount = 0; ClearFlags -> Underflow = 0; ClearFlags plus a second InRead on an empty FIFO -> Underflow stays 1.
REQ-024 Output backpressure: 5 OutputWrites (0xA000..0xA004) with ext_out_ready = 0 -> OutCount = 4, Overflow = 1, ext_out_data = 0xA000; then ready = 1 -> 0xA000..0xA003 delivered, and 0xA004 never appears.
REQ-025 Full with concurrent pop: OutCount = 4, OutputWrite 0xBEEF while ext_out_ready = 1 -> OutCount stays 4, Overflow stays 0, and 0xBEEF is delivered fifth.
REQ-026 Wrap-around: 10 interleaved push/pop pairs on the input FIFO with values 0..9 -> values read in order 0..9 and InCount never exceeds 1.
REQ-027 Async reset: assert Reset between edges with both FIFOs holding 3 words -> InCount = OutCount = 0 and ext_out_valid = 0 before the next edge; after release, the next push is accepted normally.
